uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver; downstream partner of UART_TX (consumes its tx line).
//   Synchronises the async rx line, validates start bit at mid-bit, samples 8
//   data bits LSB-first at bit centres, checks stop bit. Delivers each byte as
//   a one-cycle rx_valid pulse; flags bad stop bits via framing_error.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); must be >= 8
//   SYNC_STAGES   2    rx synchroniser depth (>= 2)
// PORTS
//   clk            in   1  system clock, 50 MHz
//   reset          in   1  synchronous, active-high reset
//   rx             in   1  async serial input, idle high
//   rx_data        out  8  last good byte; held until next good byte
//   rx_valid       out  1  one-cycle pulse, rx_data updated same cycle
//   framing_error  out  1  one-cycle pulse, stop bit sampled low
//   busy           out  1  high while a frame is being received
// BEHAVIOUR
//   Reset: rx_data=0x00, rx_valid=0, framing_error=0, busy=0, sync flops=0,
//     bit counter=0, clk counter=0, state=WAIT_IDLE.
//   rx_s = last synchroniser stage; all decisions use rx_s only.
//   Clock counter width $clog2(CLKS_PER_BIT); cleared on every state change.
//   States:
//   - WAIT_IDLE: busy=0; -> IDLE when rx_s==1. Stops false start on a low line.
//   - IDLE: busy=0; rx_s==0 -> START, counter=0.
//   - START: busy=1; at counter==CLKS_PER_BIT/2-1 sample rx_s:
//       0 -> DATA (counter=0, bit index=0); 1 -> glitch, IDLE, no outputs.
//   - DATA: busy=1; at counter==CLKS_PER_BIT-1 shift rx_s into MSB of shift
//       reg (right shift => LSB-first); after bit index 7 -> STOP.
//   - STOP: busy=1; at counter==CLKS_PER_BIT-1 sample rx_s:
//       1 -> rx_data<=shift reg, rx_valid=1 for that one cycle, -> IDLE;
//       0 -> framing_error=1 one cycle, rx_data unchanged, -> WAIT_IDLE.
//   busy falls in the cycle the output pulse is asserted.
//   Latency: rx_valid at stop-bit centre + SYNC_STAGES cycles after line edge.
//   Back-to-back frames: return to IDLE at stop-bit centre so a start bit
//     immediately after stop is caught (>= half-bit margin).
//   rx_valid and framing_error never both high; neither high outside STOP exit.
//   No flow control: a new byte overwrites rx_data; consumer must capture on
//     the rx_valid pulse.
//   Reset mid-frame: all state and outputs to reset values next edge; partial
//     frame never reported; reception resumes only after rx_s seen high.
// TESTING (CLKS_PER_BIT=434, 20 ns clk, bench drives rx at 8680 ns/bit)
//   1. reset 1000 cycles, rx=1, send 0xA5 -> single rx_valid, rx_data=0xA5,
//      framing_error never high, busy high ~9.5 bit times then low.
//   2. 0x3C then 0x1D, no idle gap between stop and next start -> two rx_valid
//      pulses, rx_data 0x3C then 0x1D, no framing_error.
//   3. rx low 100 cycles then high (< half bit) -> busy pulses, returns to IDLE,
//      no rx_valid, no framing_error; following 0xA5 received correctly.
//   4. frame 0x55 with stop bit driven 0, line held low 2 bit times, then high
//      -> framing_error one pulse, no rx_valid, rx_data keeps prior value; next
//      0x1D received correctly.
//   5. reset asserted during DATA bit 3 of 0xA5 -> outputs 0 next edge, no
//      pulse; after rx idle >= 10 bit times, 0x3C received correctly.
//   6. loopback: UART_TX.tx -> uart_rx.rx, send 0xA5, 0x3C, 0x1D via tx_start
//      -> three rx_valid pulses, data in order, each after UART_TX busy falls.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Purpose
//   Receives 8N1 serial frames on an asynchronous, idle-high line. The line is
//   first passed through a flop synchroniser. The start bit is confirmed at
//   its centre, and the 8 data bits are sampled LSB-first at their centres.
//   The stop bit is checked at its centre. A good byte is delivered with a
//   one-cycle rx_valid pulse. A low stop bit gives a one-cycle framing_error
//   pulse instead.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (must be >= 8)
//   SYNC_STAGES   depth of the rx synchroniser (must be >= 2)
//
// Ports
//   clk            in   1  system clock
//   reset          in   1  synchronous, active-high reset
//   rx             in   1  asynchronous serial input, idle high
//   rx_data        out  8  last good byte; held until the next good byte
//   rx_valid       out  1  one-cycle pulse; rx_data is updated the same cycle
//   framing_error  out  1  one-cycle pulse; the stop bit was sampled low
//   busy           out  1  high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Counter values at which the line is sampled. The start bit is sampled at
    // the half-bit point. Every later sample is one full bit after the
    // previous one, so each sample lands at a bit centre.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,  // wait for a high line before arming start detection
        IDLE,       // armed: a low line begins a frame
        START,      // confirm the start bit at its centre
        DATA,       // sample 8 data bits at their centres
        STOP        // check the stop bit at its centre
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // -------------------------------------------------------------------------
    // Input synchroniser. All later decisions use only rx_s.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // NOTE: the synchroniser flops reset to 0 (a low line) on purpose. After
    // reset the FSM therefore sits in WAIT_IDLE until a real high level has
    // passed through every stage. A line that is already low never looks like
    // a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Receive FSM. All outputs are registered here.
    // Every state change clears clk_cnt, so each state times from zero.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. The pulse
    // defaults at the top of the else branch are overridden later in the same
    // block, and the last non-blocking assignment wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;

            case (state)
                WAIT_IDLE: begin
                    busy    <= 1'b0;
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    busy    <= 1'b0;
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // The line went high again before mid-bit. This
                            // was a glitch, not a start bit: re-arm silently.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        // Shift right, entering at the MSB. After eight bits
                        // the first (LSB-first) bit ends up in bit 0.
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        // Leave at the stop-bit centre, half a bit early. This
                        // lets a start bit that follows the stop bit directly
                        // be caught from IDLE.
                        clk_cnt <= '0;
                        busy    <= 1'b0;
                        if (rx_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // The line is low where the stop bit should be
                            // high. Wait for it to go high again before
                            // looking for another start bit.
                            framing_error <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= WAIT_IDLE;
                    clk_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (CLKS_PER_BIT = 434, 20 ns clk)
//
// A table of frames is applied in a loop; each row holds the byte and stop
// bit to send plus the expected pulse counts and rx_data afterwards. Hand
// sequences cover back-to-back frames, a short start glitch, reset mid-frame
// and a transmitter-style burst. A negedge monitor counts output pulses and
// watches for protocol violations.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLKS = 434;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       busy;

    always #10 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CLKS),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    int         valid_cnt      = 0;
    int         fe_cnt         = 0;
    int         overlap_cnt    = 0;
    int         long_pulse_cnt = 0;
    int         valid_busy_cnt = 0;
    int         busy_run       = 0;
    int         first_busy_len = -1;
    bit         busy_seen      = 1'b0;
    bit         prev_valid     = 1'b0;
    bit         prev_fe        = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            got_q.push_back(rx_data);
        end
        if (framing_error) fe_cnt++;
        if (rx_valid && framing_error) overlap_cnt++;
        if ((rx_valid && prev_valid) || (framing_error && prev_fe)) long_pulse_cnt++;
        if (rx_valid && busy) valid_busy_cnt++;
        if (busy) begin
            busy_seen = 1'b1;
            busy_run++;
        end else if (busy_run > 0) begin
            if (first_busy_len < 0) first_busy_len = busy_run;
            busy_run = 0;
        end
        prev_valid = rx_valid;
        prev_fe    = framing_error;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(CLKS);
    endtask

    // Start bit, 8 data bits LSB-first, one stop bit of the given level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        int         v0;
        int         f0;
        int         q0;
        logic [7:0] tx_bytes[3];

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[2] = '{8'h55, 1'b0, 0, 1, 8'h3C};  // bad stop: data keeps 0x3C
        vecs[3] = '{8'h1D, 1'b1, 1, 0, 8'h1D};
        vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

        // ---- reset ----
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(1000);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_framing_error", framing_error, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        wait_clks(20);

        // ---- table-driven frames ----
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            f0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            if (!vecs[i].stop_bit) begin
                rx = 1'b0;
                wait_clks(2 * CLKS);
                rx = 1'b1;
            end
            wait_clks(CLKS);
            check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_fe_pulses", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
        end

        // The first frame keeps busy high for half a start bit, eight data
        // bits and one stop bit: 217 + 8*434 + 434 = 4123 cycles.
        check("busy_len_first_frame",
              (first_busy_len >= 4115 && first_busy_len <= 4131), 1'b1);

        // ---- back-to-back frames, no idle gap ----
        v0 = valid_cnt;
        f0 = fe_cnt;
        q0 = got_q.size();
        send_frame(8'h3C, 1'b1);
        send_frame(8'h1D, 1'b1);
        wait_clks(CLKS);
        check("b2b_valid_pulses", valid_cnt - v0, 2);
        check("b2b_fe_pulses", fe_cnt - f0, 0);
        check("b2b_first_byte", (got_q.size() >= q0 + 2) ? got_q[q0] : 8'hxx, 8'h3C);
        check("b2b_second_byte", (got_q.size() >= q0 + 2) ? got_q[q0 + 1] : 8'hxx, 8'h1D);

        // ---- start glitch shorter than half a bit ----
        v0        = valid_cnt;
        f0        = fe_cnt;
        busy_seen = 1'b0;
        rx        = 1'b0;
        wait_clks(100);
        rx = 1'b1;
        wait_clks(CLKS);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_idle", busy, 1'b0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_fe", fe_cnt - f0, 0);
        send_frame(8'hA5, 1'b1);
        wait_clks(CLKS);
        check("after_glitch_valid", valid_cnt - v0, 1);
        check("after_glitch_data", rx_data, 8'hA5);

        // ---- reset during data bit 3 ----
        v0 = valid_cnt;
        f0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(8'hA5 >> i);
        rx = 1'b0;  // bit 3 of 0xA5
        wait_clks(CLKS / 2);
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        wait_clks(1);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_busy", busy, 1'b0);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_fe", framing_error, 1'b0);
        wait_clks(2);
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(10 * CLKS);
        check("midreset_no_valid", valid_cnt - v0, 0);
        check("midreset_no_fe", fe_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        wait_clks(CLKS);
        check("after_reset_valid", valid_cnt - v0, 1);
        check("after_reset_data", rx_data, 8'h3C);

        // ---- transmitter-style burst: one idle bit between frames ----
        tx_bytes = '{8'hA5, 8'h3C, 8'h1D};
        v0 = valid_cnt;
        q0 = got_q.size();
        for (int i = 0; i < 3; i++) begin
            send_frame(tx_bytes[i], 1'b1);
            send_bit(1'b1);
        end
        check("burst_valid_pulses", valid_cnt - v0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("burst_byte%0d", i),
                  (got_q.size() >= q0 + 3) ? got_q[q0 + i] : 8'hxx, tx_bytes[i]);
        end

        // ---- global protocol properties ----
        check("valid_fe_overlap", overlap_cnt, 0);
        check("pulse_longer_than_one", long_pulse_cnt, 0);
        check("valid_while_busy", valid_busy_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
